lcd_cmd_sequencer: RTL

Parametrised HD44780-style character-LCD bus sequencer, the next-generation LCD driver. It latches a burst of up to DEPTH command/data entries on a start strobe and plays them out on the LCD bus with programmable setup, enable-pulse, hold and settle timing. It supports 8-bit and 4-bit bus modes and applies a long settle time after clear/home commands. It sits between the display-content logic and the LCD pins, and reports completion with busy/done.

---
 rtl/lcd_cmd_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// HD44780-style character-LCD bus sequencer. Latches a burst of up to DEPTH
// command/data entries on a start strobe and plays them onto the LCD bus
// with programmable setup, enable-pulse, hold and settle timing. Supports
// 8-bit and 4-bit (high nibble first) bus modes, and applies a long settle
// after clear/home commands.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   start     one-cycle burst request, accepted only while busy=0
//   entries   packed entries, entry i = entries[9*i +: 9] = {RS, byte}
//   count     number of entries to send (clamped to DEPTH), sampled with start
//   busy      high while a burst is in progress
//   done      one-cycle pulse when a burst finishes
//   lcd_data  DB7..DB0 (4-bit mode: nibble on [7:4], [3:0]=0)
//   lcd_rs    register select
//   lcd_rw    read/write, always write (0)
//   lcd_en    enable strobe
//
// state | meaning
// IDLE  | waiting for start; bus outputs hold the last entry
// SETUP | RS/data stable, enable low
// PULSE | enable high
// HOLD  | enable low, RS/data still held
// WAIT  | settle time after an entry (long for clear/home)
module lcd_cmd_sequencer #(
  parameter int DEPTH         = 4,
  parameter int BUS_4BIT      = 0,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 80000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [9*DEPTH-1:0]           entries,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   lcd_data,
  output logic                         lcd_rs,
  output logic                         lcd_rw,
  output logic                         lcd_en
);

  localparam int CW    = $clog2(DEPTH+1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX01 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX23 = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
  localparam int MAXA  = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int MAXC  = (MAXA > LONG_WAIT_CYC) ? MAXA : LONG_WAIT_CYC;
  localparam int TW    = $clog2(MAXC + 1);

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] WAIT_LD  = TW'(WAIT_CYC - 1);
  localparam logic [TW-1:0] LONG_LD  = TW'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t             state, stateNext;
  logic [TW-1:0]      timer, timerNext;
  logic [IW-1:0]      idx, idxNext;
  logic               lowNib, lowNibNext;
  logic [9*DEPTH-1:0] entriesReg;
  logic [CW-1:0]      countReg, countClamped;
  logic               doneNext, latchBurst, loadBus;
  logic [8:0]         curEntry, nextEntry;
  logic [9*DEPTH-1:0] srcEntries;
  logic               isLongWait, lastEntry;

  assign countClamped = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
  assign lastEntry    = ((CW'(idx) + CW'(1)) == countReg);
  assign isLongWait   = ~curEntry[8] &&
                        (curEntry[7:0] == 8'h01 || curEntry[7:0] == 8'h02 ||
                         curEntry[7:0] == 8'h03);

  // Entry currently on the bus (drives the settle-length decision).
  always_comb begin
    curEntry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IW'(i) == idx) curEntry = entriesReg[9*i +: 9];
    end
  end

  // Entry about to be driven; on the start cycle it comes straight from the
  // input port because the burst registers are loaded on the same edge.
  assign srcEntries = (state == IDLE) ? entries : entriesReg;
  always_comb begin
    nextEntry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IW'(i) == idxNext) nextEntry = srcEntries[9*i +: 9];
    end
  end

  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    idxNext    = idx;
    lowNibNext = lowNib;
    doneNext   = 1'b0;
    latchBurst = 1'b0;
    loadBus    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latchBurst = 1'b1;
          if (countClamped == '0) begin
            doneNext = 1'b1;
          end else begin
            stateNext  = SETUP;
            timerNext  = SETUP_LD;
            idxNext    = '0;
            lowNibNext = 1'b0;
            loadBus    = 1'b1;
          end
        end
      end
      SETUP: begin
        if (timer == '0) begin
          stateNext = PULSE;
          timerNext = PULSE_LD;
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      PULSE: begin
        if (timer == '0) begin
          stateNext = HOLD;
          timerNext = HOLD_LD;
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      HOLD: begin
        if (timer == '0) begin
          if ((BUS_4BIT != 0) && !lowNib) begin
            stateNext  = SETUP;
            timerNext  = SETUP_LD;
            lowNibNext = 1'b1;
            loadBus    = 1'b1;
          end else begin
            stateNext = WAIT;
            timerNext = isLongWait ? LONG_LD : WAIT_LD;
          end
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      WAIT: begin
        if (timer == '0) begin
          if (lastEntry) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            stateNext  = SETUP;
            timerNext  = SETUP_LD;
            idxNext    = idx + IW'(1);
            lowNibNext = 1'b0;
            loadBus    = 1'b1;
          end
        end else begin
          timerNext = timer - TW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      lowNib     <= 1'b0;
      entriesReg <= '0;
      countReg   <= '0;
      done       <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
    end else begin
      state  <= stateNext;
      timer  <= timerNext;
      idx    <= idxNext;
      lowNib <= lowNibNext;
      done   <= doneNext;
      // Registered enable keeps the LCD strobe glitch-free.
      lcd_en <= (stateNext == PULSE);
      if (latchBurst) begin
        entriesReg <= entries;
        countReg   <= countClamped;
      end
      if (loadBus) begin
        lcd_rs <= nextEntry[8];
        if (BUS_4BIT != 0) begin
          lcd_data <= lowNibNext ? {nextEntry[3:0], 4'h0} : {nextEntry[7:4], 4'h0};
        end else begin
          lcd_data <= nextEntry[7:0];
        end
      end
    end
  end

  assign busy   = (state != IDLE);
  assign lcd_rw = 1'b0;

endmodule
